spi_responder: RTL and testbench
================================

SPI_RESPONDER -- requirements
Module: spi_responder

Interface
REQ-001 Parameter DATA_WIDTH, default 12, frame length in bits.
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth for sclk/cs/mosi (minimum 2).
REQ-003 clk  input  1  system clock; all logic on posedge clk.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 sclk  input  1  SPI clock from external master, asynchronous to clk, idle low.
REQ-006 cs  input  1  chip select, active-low, asynchronous.
REQ-007 mosi  input  1  serial data from master, asynchronous.
REQ-008 miso  output  1  serial data to master.
REQ-009 tx_data  input  DATA_WIDTH  word to return in the next frame.
REQ-010 tx_valid  input  1  tx_data write strobe.
REQ-011 tx_ready  output  1  tx holding buffer empty; write accepted when tx_valid && tx_ready.
REQ-012 rx_data  output  DATA_WIDTH  last complete word received.
REQ-013 rx_valid  output  1  one-clk pulse: rx_data updated.
REQ-014 busy  output  1  high from frame start until cs deasserts.
REQ-015 underrun  output  1  one-clk pulse: frame started with empty tx buffer.
REQ-016 frame_err  output  1  one-clk pulse: cs deasserted before DATA_WIDTH bits received.

Function
REQ-017 sclk, cs, mosi SHALL pass through SYNC_STAGES-flop synchronizers; edges detected by comparing the last synchronized value against one further registered copy.
REQ-018 Supported sclk rate: each sclk half-period SHALL be >= 3 clk periods; the block need not tolerate faster sclk.
REQ-019 SPI mode 0, LSB first: mosi sampled on synchronized sclk rise; miso updated on synchronized sclk fall.
REQ-020 States: IDLE, SHIFT, HOLD.
REQ-021 IDLE -> SHIFT on synchronized cs falling edge: tx_shift loads the buffer (zeros if empty, with underrun pulse), buffer marked empty, bit_cnt = 0, miso = tx_shift bit 0 in the same cycle.
REQ-022 SHIFT, sclk rise: rx_shift = {mosi_s, rx_shift[DATA_WIDTH-1:1]}, bit_cnt += 1.
REQ-023 SHIFT, sclk fall with bit_cnt < DATA_WIDTH: miso = tx_shift[bit_cnt].
REQ-024 When bit_cnt reaches DATA_WIDTH: rx_data <= assembled word, rx_valid pulses for exactly 1 clk, state -> HOLD; rx_valid asserts SYNC_STAGES+2 clk after the raw final sclk rise.
REQ-025 HOLD: all sclk edges ignored, miso = 0; synchronized cs rise -> IDLE.
REQ-026 SHIFT with synchronized cs rise (bit_cnt < DATA_WIDTH): frame_err pulse, rx_data unchanged, no rx_valid, -> IDLE.
REQ-027 miso SHALL be 0 in IDLE and HOLD; busy = (state != IDLE).
REQ-028 tx buffer is a single DATA_WIDTH register; tx_ready = buffer empty; writes accepted in any state, including during a frame (word held for the next frame).
REQ-029 Write in the same cycle as frame start: frame uses pre-cycle buffer contents; when the buffer was empty, frame sends zeros with underrun and the new word is retained for the following frame.
REQ-030 tx_valid while tx_ready = 0 SHALL be ignored; buffer contents unchanged.

Reset
REQ-031 On reset: state IDLE, miso 0, rx_data 0, rx_valid 0, busy 0, underrun 0, frame_err 0, tx_ready 1, buffer empty, bit_cnt 0, shift registers 0.
REQ-032 Synchronizer flops SHALL reset to idle levels (sclk 0, cs 1, mosi 0) so no spurious edge is detected on reset release.
REQ-033 Reset mid-frame aborts without rx_valid or frame_err; a frame already in progress at release is ignored until cs rises and falls again.

Verification
REQ-034 Write 0xA5C, master sends 0x3F1 (sclk half-period 6 clk) -> rx_data 0x3F1, one rx_valid pulse, master captures 0xA5C, no underrun.
REQ-035 No write, master sends 0x800 -> underrun pulse at frame start, miso all zeros, rx_data 0x800 with rx_valid.
REQ-036 cs raised after 5 bits of 0x7FF -> frame_err pulse, no rx_valid, rx_data unchanged; next full frame 0x155 received correctly.
REQ-037 Write 0x001, start frame, write 0xFFF mid-frame, then write 0x0AA while tx_ready = 0 -> first frame returns 0x001, second returns 0xFFF, 0x0AA dropped.
REQ-038 Reset asserted after 7 bits -> all outputs at reset values the next clk; following frame with preloaded 0x123 returns 0x123 and receives master word correctly.
REQ-039 14 sclk pulses within one cs-low window -> exactly one rx_valid for the first 12 bits; extra pulses ignored, miso 0.

Source files
------------

// File: rtl/spi_responder.sv
// SPI mode-0 responder, LSB first: receives DATA_WIDTH-bit frames from an external master
// and returns a word from a single-entry tx holding buffer. All pins are synchronized into clk.
module spi_responder #(
  parameter int DATA_WIDTH  = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sclk,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  underrun,
  output logic                  frame_err
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0]  cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0]  mosi_sync_q, mosi_sync_d;
  logic                    sclk_prev_q, sclk_prev_d;
  logic                    cs_prev_q, cs_prev_d;
  logic [SYNC_STAGES:0]    warm_q, warm_d;
  logic                    armed_q, armed_d;
  logic [DATA_WIDTH-1:0]   buf_q, buf_d;
  logic                    buf_full_q, buf_full_d;
  logic [DATA_WIDTH-1:0]   tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0]   rx_shift_q, rx_shift_d;
  logic [CW-1:0]           bit_cnt_q, bit_cnt_d;
  logic                    miso_q, miso_d;
  logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
  logic                    rx_valid_q, rx_valid_d;
  logic                    underrun_q, underrun_d;
  logic                    frame_err_q, frame_err_d;

  logic sclk_s, cs_s, mosi_s, sclk_rise, sclk_fall, cs_fall, cs_rise, wr;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  assign wr        = tx_valid & ~buf_full_q;

  always_comb begin
    state_d     = state_q;
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    sclk_prev_d = sclk_s;
    cs_prev_d   = cs_s;
    warm_d      = {warm_q[SYNC_STAGES-1:0], 1'b1};
    // Frames may only start once cs has been seen idle-high with a flushed synchronizer,
    // so a frame already in progress when reset releases is ignored.
    armed_d     = armed_q | (warm_q[SYNC_STAGES] & cs_s & cs_prev_q);
    buf_d       = buf_q;
    buf_full_d  = buf_full_q;
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    bit_cnt_d   = bit_cnt_q;
    miso_d      = miso_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    underrun_d  = 1'b0;
    frame_err_d = 1'b0;

    if (wr) begin
      buf_d      = tx_data;
      buf_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (armed_q && cs_fall) begin
          state_d    = SHIFT;
          tx_shift_d = buf_full_q ? buf_q : '0;
          underrun_d = ~buf_full_q;
          buf_full_d = wr;
          bit_cnt_d  = '0;
          rx_shift_d = '0;
          miso_d     = buf_full_q ? buf_q[0] : 1'b0;
        end
      end
      SHIFT: begin
        if (bit_cnt_q == CW'(DATA_WIDTH)) begin
          rx_data_d  = rx_shift_q;
          rx_valid_d = 1'b1;
          miso_d     = 1'b0;
          state_d    = HOLD;
        end else if (cs_rise) begin
          frame_err_d = 1'b1;
          miso_d      = 1'b0;
          state_d     = IDLE;
        end else if (sclk_rise) begin
          rx_shift_d = {mosi_s, rx_shift_q[DATA_WIDTH-1:1]};
          // tx_shift advances on each rise so bit 0 is always tx bit bit_cnt.
          tx_shift_d = tx_shift_q >> 1;
          bit_cnt_d  = bit_cnt_q + CW'(1);
        end else if (sclk_fall) begin
          miso_d = tx_shift_q[0];
        end
      end
      HOLD: begin
        miso_d = 1'b0;
        // Level check: a cs rise coinciding with frame completion must not strand us here.
        if (cs_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      warm_q      <= '0;
      armed_q     <= 1'b0;
      buf_q       <= '0;
      buf_full_q  <= 1'b0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      bit_cnt_q   <= '0;
      miso_q      <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q   <= cs_prev_d;
      warm_q      <= warm_d;
      armed_q     <= armed_d;
      buf_q       <= buf_d;
      buf_full_q  <= buf_full_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      bit_cnt_q   <= bit_cnt_d;
      miso_q      <= miso_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign miso      = miso_q;
  assign tx_ready  = ~buf_full_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign busy      = (state_q != IDLE);
  assign underrun  = underrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_responder.sv
// Bench for spi_responder: table of full frames plus hand-written corner sequences;
// received words are checked through a scoreboard queue popped on rx_valid.
module tb_spi_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sclk = 1'b0;
  logic        cs = 1'b1;
  logic        mosi = 1'b0;
  logic        miso;
  logic [11:0] tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [11:0] rx_data;
  logic        rx_valid;
  logic        busy;
  logic        underrun;
  logic        frame_err;

  spi_responder #(.DATA_WIDTH(12), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .underrun(underrun), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int rxv_cnt = 0, ur_cnt = 0, fe_cnt = 0;
  int rxv_cyc = 0, last_rise = 0;
  logic [11:0] sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard / pulse monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (underrun) ur_cnt++;
      if (frame_err) fe_cnt++;
      if (rx_valid) begin
        rxv_cnt++;
        rxv_cyc = cyc;
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_unexpected: got rx_valid with rx_data %0h, expected none", rx_data);
        end else begin
          check("sb_rx_data", rx_data, sb.pop_front());
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic write_word(input logic [11:0] w);
    @(negedge clk);
    tx_data  = w;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Master clocks n bits (half-period 6 clk), capturing miso on each rise.
  task automatic clock_bits(input logic [11:0] w, input int n, output logic [11:0] cap);
    cap = '0;
    for (int i = 0; i < n; i++) begin
      mosi = w[i % 12];
      repeat (6) @(negedge clk);
      sclk = 1'b1;
      last_rise = cyc;
      if (i < 12) cap[i] = miso;
      else check("hold_miso", miso, 0);
      if (i == 0) check("busy_in_frame", busy, 1);
      repeat (6) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [11:0] w, input int n, output logic [11:0] cap);
    @(negedge clk);
    cs = 1'b0;
    repeat (6) @(negedge clk);
    clock_bits(w, n, cap);
    repeat (6) @(negedge clk);
    cs = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_miso"}, miso, 0);
    check({tag, "_rx_data"}, rx_data, 0);
    check({tag, "_rx_valid"}, rx_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_underrun"}, underrun, 0);
    check({tag, "_frame_err"}, frame_err, 0);
    check({tag, "_tx_ready"}, tx_ready, 1);
  endtask

  typedef struct {
    logic        preload;
    logic [11:0] tx;
    logic [11:0] mw;
    logic [11:0] exp_cap;
    int          exp_ur;
  } vec_t;

  initial begin
    vec_t vecs[4];
    logic [11:0] cap, cap2;
    int ur0, rx0, fe0;

    vecs[0] = '{1'b1, 12'hA5C, 12'h3F1, 12'hA5C, 0};
    vecs[1] = '{1'b0, 12'h000, 12'h800, 12'h000, 1};
    vecs[2] = '{1'b1, 12'hFFF, 12'h000, 12'hFFF, 0};
    vecs[3] = '{1'b1, 12'h5A5, 12'hA5A, 12'h5A5, 0};

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // Table-driven full frames
    foreach (vecs[k]) begin
      if (vecs[k].preload) write_word(vecs[k].tx);
      ur0 = ur_cnt; rx0 = rxv_cnt;
      sb.push_back(vecs[k].mw);
      send_frame(vecs[k].mw, 12, cap);
      check($sformatf("v%0d_miso_word", k), cap, vecs[k].exp_cap);
      check($sformatf("v%0d_underrun", k), ur_cnt - ur0, vecs[k].exp_ur);
      check($sformatf("v%0d_rx_pulses", k), rxv_cnt - rx0, 1);
      check($sformatf("v%0d_latency", k), rxv_cyc - last_rise, 4);
      check($sformatf("v%0d_idle_busy", k), busy, 0);
      check($sformatf("v%0d_idle_miso", k), miso, 0);
    end

    // Short frame: 5 bits then cs rises
    fe0 = fe_cnt; rx0 = rxv_cnt;
    send_frame(12'h7FF, 5, cap);
    check("short_frame_err", fe_cnt - fe0, 1);
    check("short_rx_pulses", rxv_cnt - rx0, 0);
    check("short_rx_data", rx_data, vecs[3].mw);
    sb.push_back(12'h155);
    rx0 = rxv_cnt;
    send_frame(12'h155, 12, cap);
    check("after_err_rx_pulses", rxv_cnt - rx0, 1);
    check("after_err_miso", cap, 12'h000);

    // Mid-frame write, then a write while buffer full is dropped
    write_word(12'h001);
    sb.push_back(12'h2C3);
    fork
      send_frame(12'h2C3, 12, cap);
      begin
        repeat (40) @(negedge clk);
        check("mid_tx_ready_empty", tx_ready, 1);
        write_word(12'hFFF);
        repeat (2) @(negedge clk);
        check("mid_tx_ready_full", tx_ready, 0);
        write_word(12'h0AA);
      end
    join
    check("mid_frame1_miso", cap, 12'h001);
    ur0 = ur_cnt;
    sb.push_back(12'h0F0);
    send_frame(12'h0F0, 12, cap);
    check("mid_frame2_miso", cap, 12'hFFF);
    check("mid_frame2_underrun", ur_cnt - ur0, 0);
    ur0 = ur_cnt;
    sb.push_back(12'h999);
    send_frame(12'h999, 12, cap);
    check("mid_frame3_miso", cap, 12'h000);
    check("mid_frame3_underrun", ur_cnt - ur0, 1);

    // Write landing in the frame-start cycle with an empty buffer
    ur0 = ur_cnt;
    sb.push_back(12'h4B2);
    fork
      send_frame(12'h4B2, 12, cap);
      begin
        repeat (3) @(negedge clk);
        tx_data  = 12'h6E7;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
      end
    join
    check("same_cycle_miso", cap, 12'h000);
    check("same_cycle_underrun", ur_cnt - ur0, 1);
    ur0 = ur_cnt;
    sb.push_back(12'h1D4);
    send_frame(12'h1D4, 12, cap2);
    check("same_cycle_next_miso", cap2, 12'h6E7);
    check("same_cycle_next_underrun", ur_cnt - ur0, 0);

    // Reset after 7 bits of a frame
    write_word(12'h777);
    fe0 = fe_cnt; rx0 = rxv_cnt;
    @(negedge clk);
    cs = 1'b0;
    repeat (6) @(negedge clk);
    clock_bits(12'hABC, 7, cap);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midreset");
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("midreset_ignored_busy", busy, 0);
    check("midreset_no_frame_err", fe_cnt - fe0, 0);
    check("midreset_no_rx", rxv_cnt - rx0, 0);
    cs = 1'b1;
    repeat (10) @(negedge clk);
    write_word(12'h123);
    ur0 = ur_cnt;
    sb.push_back(12'h9C6);
    send_frame(12'h9C6, 12, cap);
    check("postreset_miso", cap, 12'h123);
    check("postreset_underrun", ur_cnt - ur0, 0);

    // 14 sclk pulses in one cs window
    write_word(12'h3A6);
    rx0 = rxv_cnt;
    sb.push_back(12'hB4D);
    send_frame(12'hB4D, 14, cap);
    check("extra_pulses_rx_count", rxv_cnt - rx0, 1);
    check("extra_pulses_miso", cap, 12'h3A6);

    repeat (5) @(negedge clk);
    check("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
